memory_access: RTL and testbench

MEMORY_ACCESS -- requirements
Module: memory_access

---
 rtl/memory_access.sv | 193 +++++++++++++++++++
 tb/tb_memory_access.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_access.sv
// Memory-access pipeline stage: issues one aligned load/store per accepted
// instruction, handles big-endian lane placement, fault pulses and writeback.
module memory_access #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic [3:0]  mem_op,
    input  logic [4:0]  dest_reg,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_reg,
    output logic [31:0] wb_data,
    output logic        misaligned,
    output logic        bus_error
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, REQ, WB} state_t;

    state_t        state_q, state_d;
    logic [3:0]    op_q, op_d;
    logic [1:0]    off_q, off_d;
    logic [4:0]    wb_reg_q, wb_reg_d;
    logic [31:0]   wb_data_q, wb_data_d;
    logic          dmem_req_q, dmem_req_d;
    logic          dmem_we_q, dmem_we_d;
    logic [31:0]   dmem_addr_q, dmem_addr_d;
    logic [31:0]   dmem_wdata_q, dmem_wdata_d;
    logic [3:0]    dmem_be_q, dmem_be_d;
    logic          misaligned_q, misaligned_d;
    logic          bus_error_q, bus_error_d;
    logic [TW-1:0] tmo_q, tmo_d;

    // Access size: 0 none, 1 byte, 2 half, 3 word.
    function automatic logic [1:0] op_size(input logic [3:0] op);
        case (op)
            4'd1, 4'd2, 4'd6: op_size = 2'd1;
            4'd3, 4'd4, 4'd7: op_size = 2'd2;
            4'd5, 4'd8:       op_size = 2'd3;
            default:          op_size = 2'd0;
        endcase
    endfunction

    logic [1:0]  in_size;
    logic        in_misaligned;
    logic [3:0]  in_be;
    logic [31:0] in_wdata;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_value;

    always_comb begin
        in_size       = op_size(mem_op);
        in_misaligned = (in_size == 2'd2 && alu_result[0]) ||
                        (in_size == 2'd3 && alu_result[1:0] != 2'b00);
        case (in_size)
            2'd1:    in_be = 4'b1000 >> alu_result[1:0];
            2'd2:    in_be = alu_result[1] ? 4'b0011 : 4'b1100;
            default: in_be = 4'b1111;
        endcase
        case (in_size)
            2'd1:    in_wdata = {4{store_data[7:0]}};
            2'd2:    in_wdata = {2{store_data[15:0]}};
            default: in_wdata = store_data;
        endcase
        // Byte offset 0 is the most significant lane, so the select base counts down.
        rd_byte = dmem_rdata[{~off_q, 3'b000} +: 8];
        rd_half = dmem_rdata[{~off_q[1], 4'b0000} +: 16];
        case (op_size(op_q))
            2'd1:    load_value = (op_q == 4'd1) ? {{24{rd_byte[7]}}, rd_byte} : {24'd0, rd_byte};
            2'd2:    load_value = (op_q == 4'd3) ? {{16{rd_half[15]}}, rd_half} : {16'd0, rd_half};
            default: load_value = dmem_rdata;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            op_q         <= '0;
            off_q        <= '0;
            wb_reg_q     <= '0;
            wb_data_q    <= '0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            dmem_be_q    <= '0;
            misaligned_q <= 1'b0;
            bus_error_q  <= 1'b0;
            tmo_q        <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            off_q        <= off_d;
            wb_reg_q     <= wb_reg_d;
            wb_data_q    <= wb_data_d;
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            dmem_be_q    <= dmem_be_d;
            misaligned_q <= misaligned_d;
            bus_error_q  <= bus_error_d;
            tmo_q        <= tmo_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        off_d        = off_q;
        wb_reg_d     = wb_reg_q;
        wb_data_d    = wb_data_q;
        dmem_req_d   = dmem_req_q;
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        dmem_be_d    = dmem_be_q;
        misaligned_d = 1'b0;
        bus_error_d  = 1'b0;
        tmo_d        = tmo_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d     = mem_op;
                    off_d    = alu_result[1:0];
                    wb_reg_d = dest_reg;
                    if (in_size == 2'd0) begin
                        wb_data_d = alu_result;
                        state_d   = WB;
                    end else if (in_misaligned) begin
                        misaligned_d = 1'b1;
                    end else begin
                        dmem_req_d   = 1'b1;
                        dmem_we_d    = (mem_op >= 4'd6);
                        dmem_addr_d  = {alu_result[31:2], 2'b00};
                        dmem_be_d    = in_be;
                        dmem_wdata_d = in_wdata;
                        tmo_d        = '0;
                        state_d      = REQ;
                    end
                end
            end
            REQ: begin
                if (dmem_ack) begin
                    dmem_req_d = 1'b0;
                    if (dmem_we_q) begin
                        state_d = IDLE;
                    end else begin
                        wb_data_d = load_value;
                        state_d   = WB;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    dmem_req_d  = 1'b0;
                    bus_error_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready   = (state_q == IDLE);
        wb_valid   = (state_q == WB) && (wb_reg_q != 5'd0);
        wb_reg     = wb_reg_q;
        wb_data    = wb_data_q;
        dmem_req   = dmem_req_q;
        dmem_we    = dmem_we_q;
        dmem_addr  = dmem_addr_q;
        dmem_wdata = dmem_wdata_q;
        dmem_be    = dmem_be_q;
        misaligned = misaligned_q;
        bus_error  = bus_error_q;
    end

endmodule

// File: tb/tb_memory_access.sv
// Bench for memory_access: transaction-level model drives expectations that a
// negedge compare process checks every cycle; directed cases pin literal values.
module tb_memory_access;

    localparam int TMO = 64;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [3:0]  mem_op;
    logic [4:0]  dest_reg;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        misaligned, bus_error;

    memory_access #(.TIMEOUT_CYCLES(TMO)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .alu_result(alu_result), .store_data(store_data), .mem_op(mem_op),
        .dest_reg(dest_reg), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid),
        .wb_reg(wb_reg), .wb_data(wb_data), .misaligned(misaligned),
        .bus_error(bus_error)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Expected outputs for the current cycle.
    logic        e_ready, e_req, e_we, e_wbv, e_mis, e_berr, e_zero;
    logic [31:0] e_addr, e_wdata, e_wbdata;
    logic [3:0]  e_be;
    logic [4:0]  e_wbreg;

    // Observations captured during a transaction for the literal pins.
    logic [31:0] o_addr, o_wdata, o_wb;
    logic [3:0]  o_be;
    logic        o_we, o_wbv, o_mis, o_berr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            chk("in_ready", 32'(in_ready), 32'(e_ready));
            chk("dmem_req", 32'(dmem_req), 32'(e_req));
            chk("wb_valid", 32'(wb_valid), 32'(e_wbv));
            chk("misaligned", 32'(misaligned), 32'(e_mis));
            chk("bus_error", 32'(bus_error), 32'(e_berr));
            if (e_req) begin
                chk("dmem_we", 32'(dmem_we), 32'(e_we));
                chk("dmem_addr", dmem_addr, e_addr);
                chk("dmem_be", 32'(dmem_be), 32'(e_be));
                chk("dmem_wdata", dmem_wdata, e_wdata);
            end
            if (e_wbv) begin
                chk("wb_reg", 32'(wb_reg), 32'(e_wbreg));
                chk("wb_data", wb_data, e_wbdata);
            end
            if (e_zero) begin
                chk("rst_we", 32'(dmem_we), 32'd0);
                chk("rst_addr", dmem_addr, 32'd0);
                chk("rst_wdata", dmem_wdata, 32'd0);
                chk("rst_be", 32'(dmem_be), 32'd0);
                chk("rst_wb_reg", 32'(wb_reg), 32'd0);
                chk("rst_wb_data", wb_data, 32'd0);
            end
        end
    end

    // ---------------- behavioural model ----------------
    function automatic int m_size(input logic [3:0] op);
        if (op == 1 || op == 2 || op == 6) return 1;
        if (op == 3 || op == 4 || op == 7) return 2;
        if (op == 5 || op == 8) return 4;
        return 0;
    endfunction

    function automatic bit m_store(input logic [3:0] op);
        return op >= 6 && op <= 8;
    endfunction

    function automatic bit m_misal(input logic [3:0] op, input logic [31:0] a);
        int sz = m_size(op);
        return (sz == 2 && a % 2 != 0) || (sz == 4 && a % 4 != 0);
    endfunction

    function automatic logic [3:0] m_be(input logic [3:0] op, input logic [31:0] a);
        int off = int'(a % 4);
        case (m_size(op))
            1:       return 4'(1 << (3 - off));
            2:       return (off < 2) ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input logic [3:0] op, input logic [31:0] sd);
        logic [31:0] b = sd & 32'hFF;
        logic [31:0] h = sd & 32'hFFFF;
        case (m_size(op))
            1:       return b * 32'h01010101;
            2:       return h * 32'h00010001;
            default: return sd;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [3:0] op, input logic [31:0] a, input logic [31:0] rd);
        int off = int'(a % 4);
        logic [31:0] v;
        case (m_size(op))
            1: begin
                v = (rd >> (8 * (3 - off))) & 32'hFF;
                if (op == 1 && v >= 32'h80) v = v | 32'hFFFFFF00;
            end
            2: begin
                v = (rd >> (8 * (2 - off))) & 32'hFFFF;
                if (op == 3 && v >= 32'h8000) v = v | 32'hFFFF0000;
            end
            default: v = rd;
        endcase
        return v;
    endfunction

    task automatic set_idle();
        e_ready = 1'b1; e_req = 1'b0; e_wbv = 1'b0; e_mis = 1'b0; e_berr = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // One instruction through the stage; dly = REQ cycle index of the ack (>= TMO withholds it).
    task automatic run_txn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] sd,
                           input logic [4:0] dest, input int dly, input logic [31:0] rd);
        o_addr = 'x; o_wdata = 'x; o_wb = 'x; o_be = 'x;
        o_we = 1'bx; o_wbv = 1'bx; o_mis = 1'bx; o_berr = 1'bx;
        in_valid = 1'b1; mem_op = op; alu_result = a; store_data = sd; dest_reg = dest;
        dmem_ack = ($urandom_range(0, 3) == 0); dmem_rdata = $urandom;
        cyc();
        in_valid = 1'b0; dmem_ack = 1'b0;
        mem_op = 4'($urandom); alu_result = $urandom; store_data = $urandom; dest_reg = 5'($urandom);
        if (m_size(op) == 0) begin
            e_ready = 1'b0; e_wbv = (dest != 0); e_wbreg = dest; e_wbdata = a;
            o_wb = wb_data; o_wbv = wb_valid;
            in_valid = 1'($urandom_range(0, 1));
            cyc();
            in_valid = 1'b0; set_idle();
        end else if (m_misal(op, a)) begin
            e_ready = 1'b1; e_mis = 1'b1;
            o_mis = misaligned; o_wbv = wb_valid;
            cyc();
            set_idle();
        end else begin
            e_ready = 1'b0; e_req = 1'b1; e_we = m_store(op);
            e_addr = a - (a % 4); e_be = m_be(op, a); e_wdata = m_wdata(op, sd);
            o_addr = dmem_addr; o_be = dmem_be; o_wdata = dmem_wdata; o_we = dmem_we;
            for (int i = 0; i < TMO; i++) begin
                in_valid = 1'($urandom_range(0, 1));
                dmem_ack = (i == dly);
                dmem_rdata = (i == dly) ? rd : $urandom;
                cyc();
                if (i == dly) break;
            end
            in_valid = 1'b0; dmem_ack = 1'b0; e_req = 1'b0;
            if (dly < TMO) begin
                if (!m_store(op)) begin
                    e_wbv = (dest != 0); e_wbreg = dest; e_wbdata = m_load(op, a, rd);
                    o_wb = wb_data; o_wbv = wb_valid;
                    cyc();
                end else begin
                    o_wbv = wb_valid;
                end
                set_idle();
            end else begin
                e_ready = 1'b1; e_berr = 1'b1;
                o_berr = bus_error; o_wbv = wb_valid;
                dmem_ack = 1'b1; dmem_rdata = $urandom;
                cyc();
                dmem_ack = 1'b0; set_idle();
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            dmem_ack = 1'($urandom_range(0, 1));
            cyc();
        end
        dmem_ack = 1'b0;
    endtask

    initial begin
        #2_000_000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $fatal(1);
    end

    initial begin
        reset = 1'b1; in_valid = 1'b1; mem_op = 4'd5; alu_result = 32'h40;
        store_data = '0; dest_reg = 5'd1; dmem_ack = 1'b1; dmem_rdata = '1;
        e_zero = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0; e_be = '0;
        e_wbreg = '0; e_wbdata = '0;
        set_idle();
        cyc();
        cyc();
        e_zero = 1'b1; chk_en = 1'b1;
        cyc();
        reset = 1'b0; in_valid = 1'b0; dmem_ack = 1'b0;
        cyc();
        e_zero = 1'b0;

        // Literal pins.
        run_txn(4'd1, 32'h00000102, 32'h0, 5'd3, 0, 32'h11228344);
        chk("pin_lb_addr", o_addr, 32'h00000100);
        chk("pin_lb_be", 32'(o_be), 32'b0010);
        chk("pin_lb_wb", o_wb, 32'hFFFFFF83);
        run_txn(4'd4, 32'h00000006, 32'h0, 5'd4, 2, 32'hAAAA8001);
        chk("pin_lhu_be", 32'(o_be), 32'b0011);
        chk("pin_lhu_wb", o_wb, 32'h00008001);
        run_txn(4'd3, 32'h00000006, 32'h0, 5'd4, 1, 32'hAAAA8001);
        chk("pin_lh_wb", o_wb, 32'hFFFF8001);
        run_txn(4'd6, 32'h00000013, 32'h000000EE, 5'd7, 0, 32'h0);
        chk("pin_sb_we", 32'(o_we), 32'd1);
        chk("pin_sb_addr", o_addr, 32'h00000010);
        chk("pin_sb_be", 32'(o_be), 32'b0001);
        chk("pin_sb_wdata", o_wdata, 32'hEEEEEEEE);
        chk("pin_sb_nowb", 32'(o_wbv), 32'd0);
        run_txn(4'd5, 32'h00000002, 32'h0, 5'd2, 0, 32'h0);
        chk("pin_lw_mis", 32'(o_mis), 32'd1);
        chk("pin_lw_mis_nowb", 32'(o_wbv), 32'd0);
        run_txn(4'd7, 32'h00000001, 32'h0, 5'd2, 0, 32'h0);
        chk("pin_sh_mis", 32'(o_mis), 32'd1);
        run_txn(4'd5, 32'h00000040, 32'h0, 5'd9, TMO, 32'h0);
        chk("pin_tmo_berr", 32'(o_berr), 32'd1);
        chk("pin_tmo_nowb", 32'(o_wbv), 32'd0);
        run_txn(4'd5, 32'h00000044, 32'h0, 5'd9, TMO - 1, 32'hCAFEF00D);
        chk("pin_last_ack_wb", o_wb, 32'hCAFEF00D);
        run_txn(4'd0, 32'h12345678, 32'h0, 5'd5, 0, 32'h0);
        chk("pin_pass_wbv", 32'(o_wbv), 32'd1);
        chk("pin_pass_wb", o_wb, 32'h12345678);
        run_txn(4'd0, 32'h12345678, 32'h0, 5'd0, 0, 32'h0);
        chk("pin_pass_dest0", 32'(o_wbv), 32'd0);

        // Reset in the middle of a request.
        in_valid = 1'b1; mem_op = 4'd5; alu_result = 32'h80; dest_reg = 5'd6;
        cyc();
        in_valid = 1'b0;
        e_ready = 1'b0; e_req = 1'b1; e_we = 1'b0; e_addr = 32'h80; e_be = 4'b1111; e_wdata = store_data;
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        set_idle(); e_zero = 1'b1;
        cyc();
        cyc();
        e_zero = 1'b0;

        // Randomized traffic.
        for (int t = 0; t < 300; t++) begin
            logic [3:0]  op;
            logic [31:0] a;
            logic [4:0]  d;
            int          dly;
            op = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) != 0) op = 4'($urandom_range(1, 8));
            a = $urandom;
            if ($urandom_range(0, 1) == 0) a = a & 32'hFFFFFFFC | 32'(a[1] & (m_size(op) == 1));
            d = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            case ($urandom_range(0, 19))
                0:       dly = TMO;
                1:       dly = TMO - 1;
                default: dly = $urandom_range(0, 5);
            endcase
            run_txn(op, a, $urandom, d, dly, $urandom);
            idle_cycles($urandom_range(0, 2));
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
